// File: rtl/timing_stim_pkg.sv
// rtl/timing_stim_pkg.sv - shared types, widths and config check for timing_stim_gen
package timing_stim_pkg;

    localparam int STIM_TW = 8;
    localparam int STIM_NW = 8;
    localparam logic [15:0] VIOL_MAX = 16'hFFFF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [STIM_TW-1:0] period;
        logic [STIM_TW-1:0] high_time;
        logic [STIM_TW-1:0] lead;
        logic [STIM_TW-1:0] hold;
        logic [STIM_NW-1:0] n_edges;
    } stim_cfg_t;

    // Sums are taken one bit wider so L+H and L+D cannot wrap.
    function automatic logic cfg_valid(stim_cfg_t c);
        logic [STIM_TW:0] lh;
        logic [STIM_TW:0] ld;
        lh = {1'b0, c.lead} + {1'b0, c.high_time};
        ld = {1'b0, c.lead} + {1'b0, c.hold};
        return !((c.period < STIM_TW'(2)) ||
                 (c.high_time == '0) ||
                 (c.high_time >= c.period) ||
                 (lh > {1'b0, c.period}) ||
                 (ld > {1'b0, c.period}) ||
                 (c.n_edges == '0));
    endfunction

endpackage

// File: rtl/timing_stim_notifier_cnt.sv
// rtl/timing_stim_notifier_cnt.sv - notifier edge detect and saturating violation counter
module timing_stim_notifier_cnt
    import timing_stim_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        notifier,
    output logic [15:0] viol_cnt
);

    logic notifier_q;

    // A clear in the same cycle as a transition wins; that transition is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            notifier_q <= 1'b0;
            viol_cnt   <= '0;
        end else begin
            notifier_q <= notifier;
            if (clear) begin
                viol_cnt <= '0;
            end else if ((notifier != notifier_q) && (viol_cnt != VIOL_MAX)) begin
                viol_cnt <= viol_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/timing_stim_gen.sv
// rtl/timing_stim_gen.sv - reference clock / data edge generator; TIMING_STIM_NOTIFIER_EN adds the violation counter
module timing_stim_gen
    import timing_stim_pkg::*;
#(
    parameter int TW = STIM_TW,
    parameter int NW = STIM_NW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [TW-1:0] period,
    input  logic [TW-1:0] high_time,
    input  logic [TW-1:0] lead,
    input  logic [TW-1:0] hold,
    input  logic [NW-1:0] n_edges,
    input  logic          notifier,
    output logic          clk_out,
    output logic          data_out,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [15:0]   viol_cnt
);

    state_t        state;
    state_t        state_nx;
    stim_cfg_t     cfg;
    stim_cfg_t     req;
    logic [TW-1:0] t;
    logic [NW-1:0] rises;
    logic          stop_seen;
    logic          accept;
    logic          reject;
    logic          last_tick;
    logic          finish;
    logic          clk_d;
    logic          data_tgl;

    assign req       = '{period, high_time, lead, hold, n_edges};
    assign accept    = (state == IDLE) && start && cfg_valid(req);
    assign reject    = (state == IDLE) && start && !cfg_valid(req);
    assign last_tick = (t == cfg.period - 1'b1);
    // The burst ends on the last tick of the N-th period, or of the period in which stop arrived.
    assign finish    = (state == RUN) && last_tick &&
                       ((rises == cfg.n_edges - 1'b1) || stop || stop_seen);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (finish) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == RUN);
        clk_d    = (state == RUN) && (t >= cfg.period - cfg.high_time);
        data_tgl = (state == RUN) && (t == cfg.period - cfg.high_time - cfg.lead);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg       <= '0;
            t         <= '0;
            rises     <= '0;
            stop_seen <= 1'b0;
            clk_out   <= 1'b0;
            data_out  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            clk_out <= clk_d;
            done    <= finish;
            err     <= reject;
            if (data_tgl) begin
                data_out <= ~data_out;
            end
            if (accept) begin
                cfg       <= req;
                t         <= '0;
                rises     <= '0;
                stop_seen <= 1'b0;
            end else if (state == RUN) begin
                t <= last_tick ? '0 : t + 1'b1;
                if (last_tick) begin
                    rises <= rises + 1'b1;
                end
                if (stop) begin
                    stop_seen <= 1'b1;
                end
            end
        end
    end

`ifdef TIMING_STIM_NOTIFIER_EN
    timing_stim_notifier_cnt u_viol (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .notifier (notifier),
        .viol_cnt (viol_cnt)
    );
`else
    logic unused_notifier;
    assign unused_notifier = notifier;
    assign viol_cnt        = '0;
`endif

endmodule

// File: tb/tb_timing_stim_gen.sv
// tb/tb_timing_stim_gen.sv - scoreboard bench for timing_stim_gen
module tb_timing_stim_gen;

`ifdef TIMING_STIM_NOTIFIER_EN
    localparam bit NOTIF_EN = 1'b1;
`else
    localparam bit NOTIF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [7:0]  period;
    logic [7:0]  high_time;
    logic [7:0]  lead;
    logic [7:0]  hold;
    logic [7:0]  n_edges;
    logic        notifier;
    logic        clk_out;
    logic        data_out;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] viol_cnt;

    timing_stim_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .high_time (high_time),
        .lead      (lead),
        .hold      (hold),
        .n_edges   (n_edges),
        .notifier  (notifier),
        .clk_out   (clk_out),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .viol_cnt  (viol_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {E_ERR, E_DONE, E_BUSY_R, E_BUSY_F, E_DATA, E_CLK_R, E_CLK_F} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       at;
    } ev_t;

    ev_t  exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    bit   data_lvl = 1'b0;
    logic p_clk, p_data, p_busy;

    function automatic string kname(ev_kind_t k);
        case (k)
            E_ERR:    return "err";
            E_DONE:   return "done";
            E_BUSY_R: return "busy_rise";
            E_BUSY_F: return "busy_fall";
            E_DATA:   return "data_edge";
            E_CLK_R:  return "clk_rise";
            default:  return "clk_fall";
        endcase
    endfunction

    task automatic observe(ev_kind_t k);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: got %s at cycle %0d, required none", kname(k), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.at != cyc) begin
                n_fail++;
                $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                         kname(k), cyc, kname(e.kind), e.at);
            end
        end
    endtask

    // Monitor: every visible output event is matched against the head of the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (err)                 observe(E_ERR);
            if (done)                observe(E_DONE);
            if (busy && !p_busy)     observe(E_BUSY_R);
            if (!busy && p_busy)     observe(E_BUSY_F);
            if (data_out !== p_data) observe(E_DATA);
            if (clk_out && !p_clk)   observe(E_CLK_R);
            if (!clk_out && p_clk)   observe(E_CLK_F);
        end
        p_clk  = clk_out;
        p_data = data_out;
        p_busy = busy;
    end

    task automatic push(ev_kind_t k, int at);
        exp_q.push_back('{k, at});
    endtask

    task automatic push_d(int at);
        push(E_DATA, at);
        data_lvl = ~data_lvl;
    endtask

    // P=10 H=4 L=2 N=3 started in cycle b.
    task automatic push_nom(int b);
        push(E_BUSY_R, b + 1);
        push_d(b + 6);  push(E_CLK_R, b + 8);  push(E_CLK_F, b + 12);
        push_d(b + 16); push(E_CLK_R, b + 18); push(E_CLK_F, b + 22);
        push_d(b + 26); push(E_CLK_R, b + 28);
        push(E_DONE, b + 31); push(E_BUSY_F, b + 31); push(E_CLK_F, b + 32);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic drain(string name);
        chk({name, "_missing_events"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_burst(int p, int h, int l, int d, int n);
        period    = p[7:0];
        high_time = h[7:0];
        lead      = l[7:0];
        hold      = d[7:0];
        n_edges   = n[7:0];
        start     = 1'b1;
        cycles(1);
        start     = 1'b0;
    endtask

    task automatic reject_case(string name, int p, int h, int l, int d, int n);
        int b;
        b = cyc;
        push(E_ERR, b + 1);
        start_burst(p, h, l, d, n);
        cycles(4);
        drain(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d events still pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        int b;
        rst = 1'b1; start = 1'b0; stop = 1'b0; notifier = 1'b0;
        period = '0; high_time = '0; lead = '0; hold = '0; n_edges = '0;
        cycles(3);
        chk("rst_clk_out", clk_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_viol_cnt", viol_cnt, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        cycles(2);

        // Nominal burst; stop while idle and start while running must both be ignored.
        stop = 1'b1; cycles(1); stop = 1'b0;
        b = cyc;
        push_nom(b);
        start_burst(10, 4, 2, 3, 3);
        chk("nominal_viol_clear", viol_cnt, 0);
        cycles(4);
        start = 1'b1; cycles(1); start = 1'b0;
        cycles(30);
        drain("nominal");

        reject_case("reject_lh", 10, 5, 6, 3, 3);
        reject_case("reject_n0", 10, 4, 2, 3, 0);
        reject_case("reject_h_ge_p", 10, 10, 0, 0, 1);
        reject_case("reject_ld", 10, 4, 2, 9, 1);
        reject_case("reject_p1", 1, 1, 0, 0, 1);

        // L=0: data edge and clock rise land in the same cycle.
        b = cyc;
        push(E_BUSY_R, b + 1);
        push_d(b + 4); push(E_CLK_R, b + 4);
        push(E_DONE, b + 5); push(E_BUSY_F, b + 5); push(E_CLK_F, b + 6);
        start_burst(4, 2, 0, 2, 1);
        cycles(8);
        drain("lead_zero");

        // Early stop in the second period.
        b = cyc;
        push(E_BUSY_R, b + 1);
        push_d(b + 6);  push(E_CLK_R, b + 8);  push(E_CLK_F, b + 12);
        push_d(b + 16); push(E_CLK_R, b + 18);
        push(E_DONE, b + 21); push(E_BUSY_F, b + 21); push(E_CLK_F, b + 22);
        start_burst(10, 4, 2, 3, 3);
        cycles(11);
        stop = 1'b1; cycles(1); stop = 1'b0;
        cycles(15);
        drain("early_stop");

        // Notifier transitions at 9, 15, 19.
        b = cyc;
        push_nom(b);
        start_burst(10, 4, 2, 3, 3);
        cycles(8);  notifier = ~notifier;
        cycles(6);  notifier = ~notifier;
        cycles(4);
        chk("viol_at_19", viol_cnt, NOTIF_EN ? 2 : 0);
        notifier = ~notifier;
        cycles(1);
        chk("viol_at_20", viol_cnt, NOTIF_EN ? 3 : 0);
        cycles(16);
        chk("viol_after_burst", viol_cnt, NOTIF_EN ? 3 : 0);
        drain("notifier");

        // Start together with a transition: count clears and the transition is lost.
        b = cyc;
        push_nom(b);
        notifier = ~notifier;
        start_burst(10, 4, 2, 3, 3);
        chk("viol_start_clear", viol_cnt, 0);
        cycles(1);
        chk("viol_lost_transition", viol_cnt, 0);
        cycles(34);
        drain("notifier_restart");

        // Reset mid-run at cycle 14.
        b = cyc;
        push(E_BUSY_R, b + 1);
        push_d(b + 6); push(E_CLK_R, b + 8); push(E_CLK_F, b + 12);
        push(E_BUSY_F, b + 15);
        if (data_lvl) push_d(b + 15);
        start_burst(10, 4, 2, 3, 3);
        cycles(13);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        chk("midrst_clk_out", clk_out, 0);
        chk("midrst_data_out", data_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_viol_cnt", viol_cnt, 0);
        cycles(10);
        drain("reset_midrun");

        b = cyc;
        push_nom(b);
        start_burst(10, 4, 2, 3, 3);
        cycles(35);
        drain("after_reset");

`ifdef TIMING_STIM_NOTIFIER_EN
        for (int i = 0; i < 65534; i++) begin
            notifier = ~notifier;
            cycles(1);
        end
        chk("viol_fffe", viol_cnt, 16'hFFFE);
        notifier = ~notifier; cycles(1);
        chk("viol_ffff", viol_cnt, 16'hFFFF);
        notifier = ~notifier; cycles(1);
        chk("viol_saturated", viol_cnt, 16'hFFFF);
`else
        for (int i = 0; i < 5; i++) begin
            notifier = ~notifier;
            cycles(1);
        end
        chk("viol_disabled", viol_cnt, 0);
`endif
        cycles(3);
        drain("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/timing_stim_gen.md
# timing_stim_gen

Stimulus generator that drives a reference clock and data waveform with programmable period, high time, setup lead and hold margin. It is the producer side of the setup/hold/width timing checks exercised by the specify-block suite: it places data edges a precise number of ticks before and after reference-clock edges. Violations reported back on a notifier toggle line are counted. It sits in the simulation/emulation harness between the test sequencer and the device under check.

## Interface
- TW, 8: width of all timing fields (ticks).
- NW, 8: width of the edge-count field.
- clk  in  1  system clock; one tick per cycle.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a burst; sampled only in IDLE.
- stop  in  1  finish the current period, then end the burst early.
- period  in  TW  P, ticks per reference period.
- high_time  in  TW  H, ticks clk_out is high.
- lead  in  TW  L, data edge to clk_out rise (setup), in ticks.
- hold  in  TW  D, minimum ticks from clk_out rise to the next data edge.
- n_edges  in  NW  N, number of rising edges in the burst.
- notifier  in  1  violation toggle line, synchronous to clk.
- clk_out  out  1  generated reference clock.
- data_out  out  1  generated data; toggles once per period.
- busy  out  1  high while a burst runs.
- done  out  1  one-cycle pulse at the end of a burst.
- err  out  1  one-cycle pulse when start is rejected.
- viol_cnt  out  16  count of notifier transitions; saturates at 16'hFFFF.

## Operation
- States: IDLE, RUN.
- In IDLE, start latches P, H, L, D and N.
- The configuration is invalid if any of these holds: P<2, H==0, H>=P, L+H>P, L+D>P, N==0.
  - Invalid: err pulses next cycle, state stays IDLE, outputs are unchanged.
  - Valid: go to RUN, clear viol_cnt and the tick counter t.
- In RUN, t counts 0..P-1 and wraps to 0.
  - clk_out is registered as (t >= P-H).
  - data_out toggles when t == P-H-L. L=0 is legal and places the data edge on the same cycle as the clock rise.
  - A rise counter increments at each wrap.
- Exit from RUN to IDLE occurs after t==P-1 of the N-th period, or of the current period if stop was seen at any point in RUN.
  - done pulses on exit.
  - clk_out is driven 0 from IDLE.
  - data_out holds its last value.
- start during RUN is ignored.
- stop in IDLE is ignored.
- Notifier:
  - A notifier_q register is maintained.
  - Each cycle where notifier != notifier_q increments viol_cnt (saturating), in any state.
  - Only start clears viol_cnt.
- Reset values: every output is 0, state is IDLE, t is 0, notifier_q is 0.
- Reset mid-burst aborts immediately; no done pulse is produced.

## Timing
- start is accepted in cycle c. RUN occupies cycles c+1 .. c+N*P; t = (k-(c+1)) mod P.
- clk_out and data_out are registered from t, so each is visible one cycle after the t value that produces it.
- busy is high in cycles c+1 .. c+N*P.
- done pulses in cycle c+N*P+1. clk_out is 0 from cycle c+N*P+2.
- err pulses in cycle c+1. busy stays 0.
- viol_cnt reads 0 in cycle c+1. A notifier transition in cycle k is visible in cycle k+1.
- A cycle that has both start and a notifier transition clears viol_cnt; the transition is lost.

## Configuration
- TIMING_STIM_NOTIFIER_EN defined: notifier_q and the saturating counter are present.
- TIMING_STIM_NOTIFIER_EN undefined: viol_cnt is tied to 0, the notifier input is unused, and no counter flops exist.

## Structure
- Package timing_stim_pkg holds:
  - state enum (IDLE, RUN);
  - packed struct stim_cfg_t {period, high_time, lead, hold, n_edges};
  - constant VIOL_MAX = 16'hFFFF.
- Sub-module timing_stim_notifier_cnt contains the edge detect and the saturating counter. It is instantiated only under TIMING_STIM_NOTIFIER_EN.

## Test plan
- Nominal burst: P=10, H=4, L=2, D=3, N=3, start at cycle 0.
  - busy cycles 1-30.
  - data_out toggles visible at cycles 6, 16, 26.
  - clk_out rises visible at 8, 18, 28; each high pulse lasts 4 cycles.
  - done at 31; clk_out is 0 from 32.
- Reject: P=10, H=5, L=6 (L+H=11>P) → err at cycle 1, busy and clk_out stay 0. Also N=0 → err.
- Early stop: nominal config with stop pulsed at cycle 12 → done at 21, exactly 2 rises.
- Notifier: toggle notifier at cycles 9, 15, 19 → viol_cnt reads 3 from cycle 20. A new start clears it to 0.
- Reset mid-run: rst at cycle 14 → cycle 15 has every output 0, no done pulse; a new start then behaves as in the nominal burst.
- Saturation, macro defined: preload 65535 notifier transitions, add one more → viol_cnt stays 16'hFFFF.
- Macro undefined: viol_cnt is always 0.
